dvp_tx: RTL and testbench
=========================

DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 SHALL have parameter P_DVP_DATA_WIDTH, default 8, meaning DVP data bus width in bits.
REQ-002 SHALL have parameter P_AXIS_DATA_WIDTH, default 64, meaning stream word width, a multiple of P_DVP_DATA_WIDTH.
REQ-003 SHALL have parameter P_CNT_WIDTH, default 12, meaning width of all timing/config counters.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_axi_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_axi_rst_n  in  1  asynchronous active-low reset.
REQ-007 s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tdata  in  P_AXIS_DATA_WIDTH  pixel byte stream, byte 0 = bits [7:0] sent first.
REQ-008 i_enable  in  1  start/continue frames.
REQ-009 i_line_bytes, i_frame_lines, i_hblank, i_vsync_len, i_vporch  in  P_CNT_WIDTH each  bytes/line (multiple of 8, nonzero), lines/frame (nonzero), pclks between lines, pclks vsync high, pclks vsync-low-to-first-href.
REQ-010 i_clr_status  in  1  pulse, clears o_underflow.
REQ-011 o_dvp_pclk  out  1  generated pixel clock, i_axi_clk/2.
REQ-012 o_dvp_vsync, o_dvp_href  out  1 each; o_dvp_data  out  P_DVP_DATA_WIDTH.
REQ-013 o_busy  out  1; o_frame_done  out  1 (one-cycle pulse); o_underflow  out  1 (sticky).

Function
REQ-014 o_dvp_pclk SHALL toggle every i_axi_clk cycle while not IDLE; vsync/href/data SHALL change only on the cycle pclk goes 1->0 (pclk fall), stable across pclk rise.
REQ-015 One "pclk tick" = one pclk fall; all counts below are in ticks.
REQ-016 FSM states IDLE, VSYNC, VPORCH, ACTIVE, HBLANK.
REQ-017 IDLE: pclk low, outputs 0, o_busy 0; i_enable=1 -> latch all config, go VSYNC.
REQ-018 VSYNC: vsync=1 for i_vsync_len ticks -> VPORCH.
REQ-019 VPORCH: vsync=0, href=0 for i_vporch ticks -> ACTIVE (line 0).
REQ-020 ACTIVE: href=1, one byte per tick, exactly i_line_bytes ticks; last line -> frame end, else -> HBLANK.
REQ-021 HBLANK: href=0, data=0 for i_hblank ticks (0 allowed: next line follows immediately) -> ACTIVE.
REQ-022 Frame end: o_frame_done pulses once; i_enable=1 -> VSYNC with freshly latched config, else -> IDLE.
REQ-023 Config changes mid-frame SHALL have no effect until next latch.
REQ-024 Stream: one 64-bit holding register plus byte index; s_axis_tready=1 when holding register empty or its last byte is consumed this cycle; transfer on tvalid&&tready.
REQ-025 Prefetch SHALL be allowed in any non-IDLE state; a word SHALL never span two lines.
REQ-026 Underflow: byte needed in ACTIVE with register empty -> drive data 0x00, href stays 1, set o_underflow, byte count still advances.
REQ-027 o_underflow cleared only by i_clr_status or reset; set and clear same cycle -> set wins.
REQ-028 i_enable deassertion mid-frame SHALL complete current frame, then IDLE.
REQ-029 Counters SHALL saturate-free compare with latched values; no wrap within legal config.

Reset
REQ-030 Reset asserted: state IDLE, all outputs 0, s_axis_tready 0, holding register empty, o_underflow 0, effective immediately (asynchronous).
REQ-031 Reset mid-frame SHALL abort without o_frame_done; buffered data discarded.

Structure
REQ-032 Shared package dvp_pkg SHALL hold state enum type and default timing constants; reusable by the receive-side controller.
REQ-033 Single sub-module dvp_tx_unpack (word-to-byte serializer with handshake) is natural; FSM/timing stays in dvp_tx.

Verification
REQ-034 Config 16 bytes x 2 lines, hblank 3, vsync 2, vporch 4; stream 4 words bytes 0x00..0x1F -> vsync 2 ticks, 4 idle ticks, href 16 ticks bytes 0x00..0x0F, 3 gap, 16 ticks 0x10..0x1F, one o_frame_done.
REQ-035 Same config, tvalid held 0 -> 32 bytes of 0x00 with href timing unchanged, o_underflow=1; i_clr_status -> 0.
REQ-036 i_enable held 1, 3 frames -> 3 o_frame_done pulses, second vsync directly after last line; config change during frame 1 appears in frame 2.
REQ-037 hblank 0 -> href stays high across 2 lines (32 contiguous ticks).
REQ-038 Reset asserted mid line 1 -> all outputs 0 same cycle, no o_frame_done; restart gives correct frame.
REQ-039 Random tvalid backpressure, tvalid high ahead of demand -> no underflow, byte order preserved, no word lost or duplicated.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP transmit/receive controllers.
// Holds the frame-timing state type, default timing constants and a
// small tick-compare helper used by the timing counters.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VPORCH,
    ST_ACTIVE,
    ST_HBLANK
  } dvp_state_e;

  localparam int unsigned DEF_LINE_BYTES  = 640;
  localparam int unsigned DEF_FRAME_LINES = 480;
  localparam int unsigned DEF_HBLANK      = 16;
  localparam int unsigned DEF_VSYNC_LEN   = 4;
  localparam int unsigned DEF_VPORCH      = 8;

  // True when a phase that has already run cnt ticks finishes on this tick.
  // Evaluated one bit wider than any counter so it cannot wrap; a length of
  // zero therefore behaves as a single tick.
  function automatic logic last_tick(input logic [31:0] cnt, input logic [31:0] len);
    return ({1'b0, cnt} + 33'd1) >= {1'b0, len};
  endfunction

endpackage

// File: rtl/dvp_tx_unpack.sv
// Word-to-byte serializer for the DVP transmitter.
// One holding register plus a byte index; byte 0 is bits [DW-1:0].
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : accept words (prefetch allowed)
//   take         : one byte is consumed this cycle
//   last         : the byte taken is the last of a line; the register is
//                  released so a word never straddles two lines
//   in_valid/in_ready/in_data : stream handshake
//   avail        : holding register full, byte_out valid
//   byte_out     : current byte
module dvp_tx_unpack
  import dvp_pkg::*;
#(
  parameter int unsigned P_DVP_DATA_WIDTH  = 8,
  parameter int unsigned P_AXIS_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         take,
  input  logic                         last,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [P_AXIS_DATA_WIDTH-1:0] in_data,
  output logic                         avail,
  output logic [P_DVP_DATA_WIDTH-1:0]  byte_out
);

  localparam int unsigned N  = P_AXIS_DATA_WIDTH / P_DVP_DATA_WIDTH;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [P_AXIS_DATA_WIDTH-1:0] word;
  logic                         full;
  logic [IW-1:0]                idx;
  logic                         drain;
  logic                         xfer;

  assign drain    = full && take && (last || (idx == IW'(N - 1)));
  assign in_ready = enable && (!full || drain);
  assign xfer     = in_valid && in_ready;
  assign avail    = full;
  assign byte_out = word[32'(idx) * P_DVP_DATA_WIDTH +: P_DVP_DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      full <= 1'b0;
      idx  <= '0;
    end else if (xfer) begin
      word <= in_data;
      full <= 1'b1;
      idx  <= '0;
    end else if (drain) begin
      full <= 1'b0;
      idx  <= '0;
    end else if (full && take) begin
      idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP (camera-style parallel video) transmitter.
// Serializes a byte stream into frames with vsync/href timing and a
// generated pixel clock at half the system clock.
//   i_axi_clk, i_axi_rst_n : clock, asynchronous active-low reset
//   s_axis_*               : pixel byte stream, byte 0 = bits [7:0]
//   i_enable               : start / continue frames
//   i_line_bytes .. i_vporch : frame timing, latched at frame start
//   i_clr_status           : clears o_underflow
//   o_dvp_*                : DVP bus (pclk, vsync, href, data)
//   o_busy, o_frame_done, o_underflow : status
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int unsigned P_DVP_DATA_WIDTH  = 8,
  parameter int unsigned P_AXIS_DATA_WIDTH = 64,
  parameter int unsigned P_CNT_WIDTH       = 12
) (
  input  logic                         i_axi_clk,
  input  logic                         i_axi_rst_n,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         i_enable,
  input  logic [P_CNT_WIDTH-1:0]       i_line_bytes,
  input  logic [P_CNT_WIDTH-1:0]       i_frame_lines,
  input  logic [P_CNT_WIDTH-1:0]       i_hblank,
  input  logic [P_CNT_WIDTH-1:0]       i_vsync_len,
  input  logic [P_CNT_WIDTH-1:0]       i_vporch,
  input  logic                         i_clr_status,
  output logic                         o_dvp_pclk,
  output logic                         o_dvp_vsync,
  output logic                         o_dvp_href,
  output logic [P_DVP_DATA_WIDTH-1:0]  o_dvp_data,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_underflow
);

  localparam int unsigned CW = P_CNT_WIDTH;

  dvp_state_e state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx, line_q, line_nx;
  logic [CW-1:0] lb_q, fl_q, hb_q, vs_q, vp_q;
  logic          pclk_q, vsync_q, href_q, done_q, done_nx, underflow_q;
  logic [P_DVP_DATA_WIDTH-1:0] data_q, data_nx;
  logic          latch, tick, take, last_byte, avail, uf_set;
  logic [P_DVP_DATA_WIDTH-1:0] cur_byte;

  // A tick is the edge on which pclk falls; all bus changes happen there.
  assign tick = (state_q != ST_IDLE) && pclk_q;

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    line_nx  = line_q;
    latch    = 1'b0;
    done_nx  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          latch    = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        if (tick) begin
          if (last_tick(32'(cnt_q), 32'(vs_q))) begin
            cnt_nx   = '0;
            line_nx  = '0;
            state_nx = (vp_q == '0) ? ST_ACTIVE : ST_VPORCH;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      ST_VPORCH: begin
        if (tick) begin
          if (last_tick(32'(cnt_q), 32'(vp_q))) begin
            cnt_nx   = '0;
            line_nx  = '0;
            state_nx = ST_ACTIVE;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (tick) begin
          if (last_tick(32'(cnt_q), 32'(lb_q))) begin
            cnt_nx = '0;
            if (last_tick(32'(line_q), 32'(fl_q))) begin
              done_nx = 1'b1;
              if (i_enable) begin
                latch    = 1'b1;
                state_nx = ST_VSYNC;
              end else begin
                state_nx = ST_IDLE;
              end
            end else begin
              line_nx  = line_q + CW'(1);
              state_nx = (hb_q == '0) ? ST_ACTIVE : ST_HBLANK;
            end
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (tick) begin
          if (last_tick(32'(cnt_q), 32'(hb_q))) begin
            cnt_nx   = '0;
            state_nx = ST_ACTIVE;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A byte is presented on every tick that lands in (or stays in) ACTIVE.
  assign take      = tick && (state_nx == ST_ACTIVE);
  assign last_byte = (cnt_nx == lb_q - CW'(1));
  assign uf_set    = take && !avail;

  always_comb begin
    data_nx = '0;
    if (take) begin
      data_nx = avail ? cur_byte : '0;
    end else if (state_nx == ST_ACTIVE) begin
      data_nx = data_q;
    end
  end

  dvp_tx_unpack #(
    .P_DVP_DATA_WIDTH (P_DVP_DATA_WIDTH),
    .P_AXIS_DATA_WIDTH(P_AXIS_DATA_WIDTH)
  ) u_unpack (
    .clk     (i_axi_clk),
    .rst_n   (i_axi_rst_n),
    .enable  (state_q != ST_IDLE),
    .take    (take),
    .last    (last_byte),
    .in_valid(s_axis_tvalid),
    .in_ready(s_axis_tready),
    .in_data (s_axis_tdata),
    .avail   (avail),
    .byte_out(cur_byte)
  );

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      lb_q        <= '0;
      fl_q        <= '0;
      hb_q        <= '0;
      vs_q        <= '0;
      vp_q        <= '0;
      pclk_q      <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      line_q  <= line_nx;
      // pclk stays low on the IDLE->VSYNC edge so the first vsync level
      // is set up a full half-period before the first rising pclk.
      pclk_q  <= (state_q != ST_IDLE) && (state_nx != ST_IDLE) && !pclk_q;
      vsync_q <= (state_nx == ST_VSYNC);
      href_q  <= (state_nx == ST_ACTIVE);
      data_q  <= data_nx;
      done_q  <= done_nx;
      if (latch) begin
        lb_q <= i_line_bytes;
        fl_q <= i_frame_lines;
        hb_q <= i_hblank;
        vs_q <= i_vsync_len;
        vp_q <= i_vporch;
      end
      if (uf_set) begin
        underflow_q <= 1'b1;
      end else if (i_clr_status) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign o_dvp_pclk   = pclk_q;
  assign o_dvp_vsync  = vsync_q;
  assign o_dvp_href   = href_q;
  assign o_dvp_data   = data_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = done_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Self-checking bench for dvp_tx: bus activity is captured once per pclk
// period and compared against a frame model built from the timing rules.
module tb_dvp_tx;

  logic        clk;
  logic        rst_n;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        i_enable;
  logic [11:0] i_line_bytes, i_frame_lines, i_hblank, i_vsync_len, i_vporch;
  logic        i_clr_status;
  logic        o_dvp_pclk, o_dvp_vsync, o_dvp_href;
  logic [7:0]  o_dvp_data;
  logic        o_busy, o_frame_done, o_underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  exp_bytes[$];
  logic [63:0] word_q[$];
  int done_cnt = 0;
  int phase_err = 0;
  int busy_falls = 0;
  int max_gap = 0;

  dvp_tx #(
    .P_DVP_DATA_WIDTH (8),
    .P_AXIS_DATA_WIDTH(64),
    .P_CNT_WIDTH      (12)
  ) dut (
    .i_axi_clk    (clk),
    .i_axi_rst_n  (rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .i_enable     (i_enable),
    .i_line_bytes (i_line_bytes),
    .i_frame_lines(i_frame_lines),
    .i_hblank     (i_hblank),
    .i_vsync_len  (i_vsync_len),
    .i_vporch     (i_vporch),
    .i_clr_status (i_clr_status),
    .o_dvp_pclk   (o_dvp_pclk),
    .o_dvp_vsync  (o_dvp_vsync),
    .o_dvp_href   (o_dvp_href),
    .o_dvp_data   (o_dvp_data),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_underflow  (o_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stream source: words leave word_q in order; after each accepted word
  // tvalid may drop for up to max_gap cycles.
  initial begin
    bit xfer;
    int gap_left;
    gap_left = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      xfer = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (xfer) begin
        if (word_q.size() > 0) void'(word_q.pop_front());
        gap_left = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      end else if (!s_axis_tvalid && gap_left > 0) begin
        gap_left--;
      end
      if (word_q.size() > 0 && gap_left == 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = word_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // Bus monitor: one sample per pclk-high phase, plus phase sanity tracking.
  initial begin
    bit have_prev;
    logic [9:0] prev_out, cur;
    logic prev_pclk, prev_busy;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 0;
      end else begin
        cur = {o_dvp_vsync, o_dvp_href, o_dvp_data};
        if (o_frame_done) done_cnt++;
        if (o_dvp_pclk) got_q.push_back(cur);
        if (have_prev) begin
          if (o_dvp_pclk && cur != prev_out) phase_err++;
          if (prev_busy && o_busy && o_dvp_pclk == prev_pclk) phase_err++;
          if (!o_busy && o_dvp_pclk) phase_err++;
          if (prev_busy && !o_busy) busy_falls++;
        end
        prev_out  = cur;
        prev_pclk = o_dvp_pclk;
        prev_busy = o_busy;
        have_prev = 1;
      end
    end
  end

  task automatic load_bytes(input int n, input bit seq);
    logic [63:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      exp_bytes.push_back(b);
      w[8*(i%8) +: 8] = b;
      if (i % 8 == 7) word_q.push_back(w);
    end
  endtask

  // Reference frame: vsync ticks, back porch, lines separated by blanking.
  task automatic model_frame(input int vs, input int vp, input int lb, input int fl, input int hb);
    logic [7:0] b;
    for (int i = 0; i < vs; i++) exp_q.push_back({2'b10, 8'h00});
    for (int i = 0; i < vp; i++) exp_q.push_back({2'b00, 8'h00});
    for (int l = 0; l < fl; l++) begin
      if (l > 0) for (int i = 0; i < hb; i++) exp_q.push_back({2'b00, 8'h00});
      for (int i = 0; i < lb; i++) begin
        b = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
        exp_q.push_back({2'b01, b});
      end
    end
  endtask

  task automatic set_cfg(input int lb, input int fl, input int hb, input int vs, input int vp);
    i_line_bytes  = 12'(lb);
    i_frame_lines = 12'(fl);
    i_hblank      = 12'(hb);
    i_vsync_len   = 12'(vs);
    i_vporch      = 12'(vp);
  endtask

  task automatic start_frame();
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    i_enable = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt >= target) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    exp_bytes.delete();
    word_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_enable = 1'b0;
    i_clr_status = 1'b0;
    set_cfg(16, 2, 3, 2, 4);
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_dvp_pclk, o_dvp_vsync, o_dvp_href, o_dvp_data, o_busy, o_frame_done, o_underflow, s_axis_tready} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pclk%b vs%b hr%b d%h busy%b done%b uf%b rdy%b, required all 0",
               o_dvp_pclk, o_dvp_vsync, o_dvp_href, o_dvp_data, o_busy, o_frame_done, o_underflow, s_axis_tready);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({o_dvp_pclk, o_busy, s_axis_tready, o_dvp_vsync} !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_quiet: got pclk%b busy%b rdy%b vs%b, required 0000", o_dvp_pclk, o_busy, s_axis_tready, o_dvp_vsync);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int base, n;
    clear_all();
    max_gap = 0;
    load_bytes(32, 1);
    set_cfg(16, 2, 3, 2, 4);
    model_frame(2, 4, 16, 2, 3);
    base = done_cnt;
    phase_err = 0;
    start_frame();
    wait_done(base + 1, ok);
    repeat (6) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no frame_done, required one"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_len: got %0d ticks, required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_tick%0d: got vs/hr/data %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt != base + 1) begin miscompares++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - base); end
    vectors++;
    if (o_underflow !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status: got uf%b busy%b, required uf0 busy0", o_underflow, o_busy);
    end
    vectors++;
    if (phase_err != 0 || word_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_phase: got %0d phase errors and %0d words left, required 0 and 0", phase_err, word_q.size());
    end
  endtask

  task automatic test_underflow();
    bit ok;
    int base, n;
    clear_all();
    set_cfg(16, 2, 3, 2, 4);
    model_frame(2, 4, 16, 2, 3);
    base = done_cnt;
    start_frame();
    wait_done(base + 1, ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL uf_timeout: got no frame_done, required one"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL uf_len: got %0d ticks, required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL uf_tick%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (o_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_flag: got %b, required 1", o_underflow); end
    repeat (3) @(negedge clk);
    vectors++;
    if (o_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b, required 1", o_underflow); end
    i_clr_status = 1'b1;
    @(negedge clk);
    i_clr_status = 1'b0;
    vectors++;
    if (o_underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %b, required 0", o_underflow); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base, n;
    clear_all();
    max_gap = 0;
    load_bytes(32 + 24 + 24, 0);
    set_cfg(16, 2, 3, 2, 4);
    model_frame(2, 4, 16, 2, 3);
    model_frame(1, 2, 8, 3, 1);
    model_frame(1, 2, 8, 3, 1);
    base = done_cnt;
    busy_falls = 0;
    phase_err = 0;
    @(negedge clk);
    i_enable = 1'b1;
    repeat (10) @(negedge clk);
    set_cfg(8, 3, 1, 1, 2);
    wait_done(base + 2, ok);
    i_enable = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout2: got %0d frames, required 2", done_cnt - base); end
    wait_done(base + 3, ok);
    repeat (6) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout3: got %0d frames, required 3", done_cnt - base); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_len: got %0d ticks, required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_tick%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt != base + 3 || busy_falls != 1) begin
      miscompares++;
      $display("FAIL b2b_frames: got %0d done pulses and %0d busy drops, required 3 and 1", done_cnt - base, busy_falls);
    end
    vectors++;
    if (phase_err != 0 || o_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_phase: got %0d phase errors, uf%b, required 0, uf0", phase_err, o_underflow);
    end
  endtask

  task automatic test_hblank0();
    bit ok;
    int base, n, run, best;
    clear_all();
    load_bytes(32, 0);
    set_cfg(16, 2, 0, 2, 4);
    model_frame(2, 4, 16, 2, 0);
    base = done_cnt;
    start_frame();
    wait_done(base + 1, ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL hb0_timeout: got no frame_done, required one"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL hb0_len: got %0d ticks, required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL hb0_tick%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    run = 0;
    best = 0;
    foreach (got_q[i]) begin
      run = got_q[i][8] ? run + 1 : 0;
      if (run > best) best = run;
    end
    vectors++;
    if (best != 32) begin miscompares++; $display("FAIL hb0_run: got href run %0d, required 32", best); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, n;
    clear_all();
    load_bytes(32, 0);
    set_cfg(16, 2, 3, 2, 4);
    base = done_cnt;
    start_frame();
    for (int i = 0; i < 2000 && got_q.size() < 29; i++) @(negedge clk);
    vectors++;
    if (got_q.size() < 29) begin miscompares++; $display("FAIL rmid_reach: got %0d ticks, required 29", got_q.size()); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_dvp_pclk, o_dvp_vsync, o_dvp_href, o_dvp_data, o_busy, o_frame_done, o_underflow, s_axis_tready} !== 15'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got pclk%b vs%b hr%b d%h busy%b done%b rdy%b, required all 0",
               o_dvp_pclk, o_dvp_vsync, o_dvp_href, o_dvp_data, o_busy, o_frame_done, s_axis_tready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt != base) begin miscompares++; $display("FAIL rmid_nodone: got %0d pulses, required 0", done_cnt - base); end
    clear_all();
    repeat (2) @(negedge clk);
    load_bytes(32, 0);
    model_frame(2, 4, 16, 2, 3);
    start_frame();
    wait_done(base + 1, ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rmid_timeout: got no frame_done, required one"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rmid_len: got %0d ticks, required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rmid_tick%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int base, n, lb, fl, hb, vs, vp;
    max_gap = 8;
    for (int it = 0; it < 5; it++) begin
      clear_all();
      lb = 8 * int'($urandom_range(4, 1));
      fl = int'($urandom_range(3, 1));
      hb = int'($urandom_range(4, 0));
      vs = int'($urandom_range(3, 1));
      vp = int'($urandom_range(3, 0));
      load_bytes(lb * fl, 0);
      set_cfg(lb, fl, hb, vs, vp);
      model_frame(vs, vp, lb, fl, hb);
      repeat (12) @(negedge clk);
      base = done_cnt;
      start_frame();
      wait_done(base + 1, ok);
      repeat (4) @(negedge clk);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rnd%0d_timeout: got no frame_done, required one", it); end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rnd%0d_len: got %0d ticks, required %0d", it, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rnd%0d_tick%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (o_underflow !== 1'b0 || word_q.size() != 0) begin
        miscompares++;
        $display("FAIL rnd%0d_stream: got uf%b, %0d words left, required uf0, 0 left", it, o_underflow, word_q.size());
      end
    end
    max_gap = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_hblank0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
